// File: rtl/i2c_pkg.sv
// i2c_pkg: I2C target state encoding and the TCS34725 register map it emulates
package i2c_pkg;
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK, ST_IGNORE
  } state_e;
  localparam logic [6:0] TCS_ADDR   = 7'h29;
  localparam logic [7:0] CMD_BIT    = 8'h80;
  localparam logic [7:0] REG_ENABLE = 8'h00;
  localparam logic [7:0] REG_CDATAL = 8'h14;
  localparam logic [7:0] REG_RDATAL = 8'h16;
  localparam logic [7:0] REG_GDATAL = 8'h18;
  localparam logic [7:0] REG_BDATAL = 8'h1A;
endpackage

// File: rtl/i2c_target_regfile_if.sv
// i2c_target_regfile_if: local-side register preload port and bus-write report
interface i2c_target_regfile_if #(parameter int PTR_W = 5);
  logic             loc_we;
  logic [PTR_W-1:0] loc_addr;
  logic [7:0]       loc_wdata;
  logic             busy;
  logic             wr_valid;
  logic [PTR_W-1:0] wr_addr;
  logic [7:0]       wr_data;
  modport master (output loc_we, loc_addr, loc_wdata, input busy, wr_valid, wr_addr, wr_data);
  modport slave (input loc_we, loc_addr, loc_wdata, output busy, wr_valid, wr_addr, wr_data);
endinterface

// File: rtl/i2c_bus_sync.sv
// i2c_bus_sync: 2-FF synchronizers for scl/sda with registered edge, START and STOP pulses
module i2c_bus_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);
  logic [2:0] scl_q, sda_q;
  always_ff @(posedge clk)
    if (rst) begin
      scl_q      <= '1;
      sda_q      <= '1;
      sda_o      <= 1'b1;
      scl_rise_o <= 1'b0;
      scl_fall_o <= 1'b0;
      start_o    <= 1'b0;
      stop_o     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      // sda_o is delayed alongside the pulses so a rise samples the bit it qualifies
      sda_o      <= sda_q[1];
      scl_rise_o <= scl_q[1] & ~scl_q[2];
      scl_fall_o <= ~scl_q[1] & scl_q[2];
      start_o    <= scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
      stop_o     <= scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];
    end
endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with a byte register file, pointer-write then repeated-start read
module i2c_target_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = TCS_ADDR,
  parameter int         NUM_REGS = 32,
  parameter int         PTR_W    = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  inout  wire  sda,
  i2c_target_regfile_if.slave bus
);
  state_e           state_q;
  logic [2:0]       cnt_q;
  logic [7:0]       shift_q;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             sda_oe_q, busy_q, wr_valid_q;
  logic [PTR_W-1:0] wr_addr_q;
  logic [7:0]       wr_data_q;
  logic [7:0]       regs_q [NUM_REGS];
  logic             sda_s, scl_rise, scl_fall, start_det, stop_det, match;
  logic [7:0]       byte_d, rd_d;
  i2c_bus_sync u_sync (
    .clk, .rst, .scl_i(scl), .sda_i(sda), .sda_o(sda_s),
    .scl_rise_o(scl_rise), .scl_fall_o(scl_fall), .start_o(start_det), .stop_o(stop_det)
  );
  assign ptr_d        = ptr_q + 1'b1;
  assign byte_d       = {shift_q[6:0], sda_s};
  assign rd_d         = regs_q[ptr_q];
  assign match        = byte_d[7:1] == DEV_ADDR;
  assign sda          = sda_oe_q ? 1'b0 : 1'bz;
  assign bus.busy     = busy_q;
  assign bus.wr_valid = wr_valid_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  always_ff @(posedge clk)
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      wr_valid_q <= 1'b0;
      if (start_det) begin
        state_q  <= ST_ADDR;
        cnt_q    <= '0;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (stop_det) begin
        state_q  <= ST_IDLE;
        sda_oe_q <= 1'b0;
        busy_q   <= 1'b0;
      end else
        case (state_q)
          ST_ADDR, ST_PTR, ST_WDATA:
            if (scl_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_q + 1'b1;
              if (cnt_q == 3'd7) begin
                if (state_q == ST_ADDR) begin
                  busy_q  <= match;
                  state_q <= match ? ST_ADDR_ACK : ST_IGNORE;
                end else if (state_q == ST_PTR) begin
                  ptr_q   <= byte_d[PTR_W-1:0];
                  state_q <= ST_PTR_ACK;
                end else begin
                  regs_q[ptr_q] <= byte_d;
                  wr_valid_q    <= 1'b1;
                  wr_addr_q     <= ptr_q;
                  wr_data_q     <= byte_d;
                  ptr_q         <= ptr_d;
                  state_q       <= ST_WDATA_ACK;
                end
              end
            end
          // first fall opens the ACK slot, second fall closes it
          ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK:
            if (scl_fall) begin
              if (cnt_q == 3'd0) begin
                sda_oe_q <= 1'b1;
                cnt_q    <= 3'd1;
              end else begin
                cnt_q    <= '0;
                sda_oe_q <= 1'b0;
                if (state_q == ST_ADDR_ACK && shift_q[0]) begin
                  state_q  <= ST_RDATA;
                  shift_q  <= rd_d;
                  sda_oe_q <= ~rd_d[7];
                  ptr_q    <= ptr_d;
                end else
                  state_q <= state_q == ST_ADDR_ACK ? ST_PTR : ST_WDATA;
              end
            end
          ST_RDATA:
            if (scl_fall) begin
              cnt_q    <= cnt_q + 1'b1;
              shift_q  <= {shift_q[6:0], 1'b0};
              sda_oe_q <= cnt_q == 3'd7 ? 1'b0 : ~shift_q[6];
              if (cnt_q == 3'd7) state_q <= ST_RACK;
            end
          ST_RACK:
            if (scl_rise) begin
              if (sda_s) begin
                state_q <= ST_IGNORE;
                busy_q  <= 1'b0;
              end else
                cnt_q <= 3'd1;
            end else if (scl_fall && cnt_q == 3'd1) begin
              cnt_q    <= '0;
              state_q  <= ST_RDATA;
              shift_q  <= rd_d;
              sda_oe_q <= ~rd_d[7];
              ptr_q    <= ptr_d;
            end
          default: ;
        endcase
      // local write placed last so it wins a same-index collision with the bus
      if (bus.loc_we) regs_q[bus.loc_addr] <= bus.loc_wdata;
    end
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: bit-banged I2C master with a register-map model and write scoreboard
module tb_i2c_target_regfile;
  import i2c_pkg::*;
  localparam int H = 16;
  localparam logic [7:0] AW = {TCS_ADDR, 1'b0};
  localparam logic [7:0] AR = {TCS_ADDR, 1'b1};
  typedef struct packed {logic [4:0] a; logic [7:0] d;} wr_t;
  logic clk = 1'b0, rst = 1'b1, scl = 1'b1, m_low = 1'b0, watch = 1'b0;
  wire sda;
  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  i2c_target_regfile_if #(.PTR_W(5)) bif ();
  i2c_target_regfile #(.DEV_ADDR(TCS_ADDR), .NUM_REGS(32), .PTR_W(5)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda), .bus(bif)
  );
  always #5 clk = ~clk;
  int errors = 0, checks = 0, low_cnt = 0;
  logic [7:0] mregs [32];
  logic [7:0] wbuf [8];
  logic [4:0] mptr;
  wr_t exp_wr[$];
  wr_t got;
  logic [7:0] exp_rd[$];

  function automatic void chk(input string n, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endfunction

  always @(negedge clk)
    if (!rst && bif.wr_valid) begin
      if (exp_wr.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", bif.wr_addr, bif.wr_data);
      end else begin
        got = exp_wr.pop_front();
        chk("wr_addr", bif.wr_addr, got.a);
        chk("wr_data", bif.wr_data, got.d);
      end
    end

  always @(posedge clk)
    if (watch && !m_low && sda === 1'b0) low_cnt++;

  task automatic w(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic start_c;
    w(4); m_low = 1'b0; w(H); scl = 1'b1; w(H); m_low = 1'b1; w(H); scl = 1'b0;
  endtask
  task automatic stop_c;
    w(4); m_low = 1'b1; w(H); scl = 1'b1; w(H); m_low = 1'b0; w(H);
  endtask
  task automatic sbit(input bit b, input bit col);
    w(4); m_low = !b; w(H); scl = 1'b1;
    if (col) begin
      w(3); bif.loc_addr = 5'h05; bif.loc_wdata = 8'hAA; bif.loc_we = 1'b1;
      w(1); bif.loc_we = 1'b0; w(H - 4);
    end else w(H);
    scl = 1'b0;
  endtask
  task automatic rbit(output bit b);
    w(4); m_low = 1'b0; w(H); scl = 1'b1; w(H / 2); b = sda; w(H / 2); scl = 1'b0;
  endtask
  task automatic wbyte(input logic [7:0] d, input bit col, output bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) sbit(d[i], col && i == 0);
    rbit(b);
    ack = !b;
  endtask
  task automatic rbyte(input bit ack, output logic [7:0] d);
    bit b;
    for (int i = 7; i >= 0; i--) begin rbit(b); d[i] = b; end
    sbit(!ack, 1'b0);
  endtask
  task automatic loc_wr(input logic [4:0] a, input logic [7:0] d);
    bif.loc_addr = a; bif.loc_wdata = d; bif.loc_we = 1'b1; w(1); bif.loc_we = 1'b0;
    mregs[a] = d;
  endtask
  task automatic bus_write(input logic [7:0] p, input int n, input bit col);
    bit a;
    start_c; wbyte(AW, 1'b0, a); chk("addr_ack_w", a, 1);
    wbyte(p, 1'b0, a); chk("ptr_ack", a, 1);
    mptr = p[4:0];
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({mptr, wbuf[i]});
      mregs[mptr] = (col && i == 0) ? 8'hAA : wbuf[i];
      mptr = 5'((mptr + 1) % 32);
      wbyte(wbuf[i], col && i == 0, a); chk("data_ack", a, 1);
    end
    stop_c; chk("busy_after_stop_w", bif.busy, 0);
  endtask
  task automatic bus_read(input bit setp, input logic [7:0] p, input int n);
    bit a;
    logic [7:0] d;
    if (setp) begin
      start_c; wbyte(AW, 1'b0, a); chk("addr_ack_w", a, 1);
      wbyte(p, 1'b0, a); chk("ptr_ack", a, 1);
      mptr = p[4:0];
    end
    start_c; wbyte(AR, 1'b0, a); chk("addr_ack_r", a, 1); chk("busy_rd", bif.busy, 1);
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(mregs[mptr]);
      mptr = 5'((mptr + 1) % 32);
      rbyte(i != n - 1, d);
      chk("rd_byte", d, exp_rd.pop_front());
    end
    chk("sda_rel_nack", sda === 1'b1, 1);
    stop_c; chk("busy_after_stop_r", bif.busy, 0);
  endtask

  initial begin
    bit a;
    int n, l0;
    bif.loc_we = 1'b0; bif.loc_addr = '0; bif.loc_wdata = '0;
    for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
    mptr = '0;
    w(4);
    chk("rst_busy", bif.busy, 0); chk("rst_wr_valid", bif.wr_valid, 0);
    chk("rst_wr_addr", bif.wr_addr, 0); chk("rst_wr_data", bif.wr_data, 0);
    chk("rst_sda", sda === 1'b1, 1);
    rst = 1'b0; w(4);
    // TCS-style color read: command pointer then repeated-start read
    loc_wr(REG_CDATAL[4:0], 8'hCD); loc_wr(5'h15, 8'hAB);
    bus_read(1'b1, CMD_BIT | REG_CDATAL, 2);
    // foreign address is ignored, a following read still works
    l0 = low_cnt; watch = 1'b1;
    start_c; wbyte(8'h60, 1'b0, a); chk("bad_addr_nack", a, 0); chk("bad_busy", bif.busy, 0);
    w(H); watch = 1'b0; chk("bad_sda_low", low_cnt - l0, 0);
    bus_read(1'b0, 8'h00, 1);
    // pointer wrap on write and readback
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; bus_write(8'h1F, 2, 1'b0);
    bus_read(1'b1, 8'h1F, 2);
    // STOP after three data bits aborts the byte
    loc_wr(5'h03, 8'h5A);
    start_c; wbyte(AW, 1'b0, a); chk("abort_addr_ack", a, 1);
    wbyte(8'h03, 1'b0, a); chk("abort_ptr_ack", a, 1); mptr = 5'h03;
    sbit(1'b1, 1'b0); sbit(1'b0, 1'b0); sbit(1'b1, 1'b0);
    stop_c; chk("abort_busy", bif.busy, 0);
    bus_read(1'b0, 8'h00, 1);
    // local and bus write to the same index in the same cycle
    wbuf[0] = 8'h55; bus_write(8'h05, 1, 1'b1);
    bus_read(1'b1, 8'h05, 1);
    repeat (10) begin
      if ($urandom_range(0, 1) == 1) loc_wr(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)));
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < n; i++) wbuf[i] = 8'($urandom_range(0, 255));
        bus_write(8'($urandom_range(0, 255)), n, 1'b0);
      end else bus_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), n);
    end
    // reset while the target holds sda low on a read data bit
    loc_wr(5'h07, 8'h3C);
    start_c; wbyte(AW, 1'b0, a); wbyte(8'h07, 1'b0, a);
    start_c; wbyte(AR, 1'b0, a); chk("rst_rd_addr_ack", a, 1);
    w(4); m_low = 1'b0; w(H); scl = 1'b1; w(2);
    chk("sda_low_pre_rst", sda === 1'b0, 1);
    rst = 1'b1; w(1);
    chk("rst_mid_sda", sda === 1'b1, 1); chk("rst_mid_busy", bif.busy, 0);
    chk("rst_mid_wr_valid", bif.wr_valid, 0); chk("rst_mid_wr_addr", bif.wr_addr, 0);
    chk("rst_mid_wr_data", bif.wr_data, 0);
    rst = 1'b0;
    for (int i = 0; i < 32; i++) mregs[i] = 8'h00;
    mptr = '0;
    w(H); scl = 1'b0; w(H); stop_c;
    bus_read(1'b0, 8'h00, 32);
    chk("wr_queue_drained", exp_wr.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_target_regfile.md
# i2c_target_regfile

I2C target (slave) with a 32-entry byte register file, answering the same register-pointer-then-repeated-start-read sequence the color-sensor I2C master issues. It is used as an on-chip TCS34725 stand-in for bring-up and simulation, and as the target-side endpoint for exposing status registers to an external I2C master. Bus-side writes are reported to local logic. Local logic preloads register contents through a dedicated write port.

## Interface
- `DEV_ADDR`, default 7'h29: 7-bit target address; TCS34725 value.
- `NUM_REGS`, default 32: register count; power of two, 2..256.
- `PTR_W`, default 5: log2(NUM_REGS).
- `clk` in 1: system clock; one clock domain.
- `rst` in 1: reset; synchronous, active-high.
- `scl` in 1: I2C clock. Asynchronous; never driven by this block; no clock stretching.
- `sda` inout 1: open drain. Driven 0 or released (`z`), never driven 1.
- `loc_we` in 1: local register write strobe.
- `loc_addr` in PTR_W: local write index.
- `loc_wdata` in 8: local write data.
- `busy` out 1: high from an address match until STOP, START, or NACK-end.
- `wr_valid` out 1: one-cycle pulse per bus-written data byte.
- `wr_addr` out PTR_W: index of the bus-written byte.
- `wr_data` out 8: value of the bus-written byte.

## Operation
- `scl` and `sda` pass through a 2-FF synchronizer and a registered edge detector.
- START: `sda` falls while `scl` is high. STOP: `sda` rises while `scl` is high. Both are detected in any state.
- START (also a repeated START) resets the bit counter and enters ADDR. STOP enters IDLE.
- Data is sampled on the `scl` rising edge. `sda` changes only after the `scl` falling edge.
- States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, IGNORE.
- ADDR: shift in 8 bits, MSB first.
  - If addr[7:1] equals DEV_ADDR, go to ADDR_ACK and drive `sda` 0 for the 9th clock.
  - Otherwise go to IGNORE with `sda` released until the next START or STOP.
- Write, R/W=0:
  - First byte goes to PTR. The pointer takes byte[PTR_W-1:0]; upper bits are ignored, so the TCS34725 command bit 0x80 is harmless. The block ACKs the byte.
  - Each later byte goes to WDATA. `regs[ptr]` is written, `wr_valid` pulses with the pre-increment ptr and the byte, the byte is ACKed, and ptr increments.
- Read, R/W=1:
  - `regs[ptr]` is loaded into the shift register at the ADDR_ACK→RDATA transition. Ptr then increments.
  - 8 bits are driven MSB first (drive 0 for a 0 bit, release for a 1 bit), then `sda` is released for RACK.
  - Master ACK (0): load the next byte, increment ptr, continue in RDATA.
  - Master NACK (1): go to IGNORE with `sda` released.
- Pointer arithmetic is modulo NUM_REGS, so 0x1F+1 wraps to 0x00. The pointer persists across transactions and resets to 0.
- Write collision: `loc_we` and a bus write to the same index in the same cycle leave `loc_wdata` in the register. The bus write still pulses `wr_valid`.
- Reset values:
  - `sda` released; `busy`, `wr_valid`, `wr_addr`, `wr_data` all 0.
  - ptr 0; all `regs` 0; state IDLE; synchronizers 1.

## Timing
- Bus-to-internal event latency is 3 `clk` (2 sync + 1 edge).
- `sda` is updated no later than 4 `clk` after a physical `scl` fall.
- `scl` high and low phases must each be ≥ 8 `clk`. The team master (~250 `clk` per phase) qualifies.
- `wr_valid` asserts 1 `clk` after the internal rising edge that samples bit 0 of a data byte, i.e. before the ACK clock.
- STOP or START mid-byte aborts the byte: no register write, no `wr_valid`, `sda` released within 1 `clk` of detection.
- `rst` asserted mid-transaction takes effect at the next `clk`. The block then waits for a START.
- `busy` falls 1 `clk` after STOP detection.

## Structure
- Package `i2c_pkg`:
  - state enum;
  - `TCS_ADDR`=7'h29 and `CMD_BIT`=8'h80;
  - register indices `REG_ENABLE`=0x00, `REG_CDATAL`=0x14, `REG_RDATAL`=0x16, `REG_GDATAL`=0x18, `REG_BDATAL`=0x1A.
- Sub-module `i2c_bus_sync` holds the synchronizers plus the `scl_rise`, `scl_fall`, `start_det` and `stop_det` pulses. It is shared with future I2C blocks.

## Test plan
- Preload 0x14=0xCD and 0x15=0xAB. Master writes 0x29/W, pointer 0x94, repeated START, 0x29/R, reads 2 bytes with ACK then NACK → three ACKs from the target, bytes 0xCD then 0xAB, `sda` released after the NACK, `busy` 0 after STOP.
- Address 0x30/W → no ACK, `sda` never low, `busy` stays 0. An immediately following valid read still succeeds.
- Write 0x29/W, pointer 0x1F, data 0x11, 0x22 → `wr_valid` pulses (0x1F,0x11) then (0x00,0x22); a readback of 0x1F returns 0x11, 0x22.
- STOP after 3 data bits of a write → no `wr_valid`, register unchanged, state IDLE.
- `rst` pulse while the target drives `sda` low during a read → `sda` released the next cycle, all outputs and `regs` 0.
- `loc_we` index 0x05 = 0xAA in the same cycle as a bus write of 0x55 to 0x05 → register holds 0xAA, `wr_valid` reports 0x55.
